// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Port B has priority; a bounded B streak guarantees port A forward progress.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned B_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] BurstMax = 8'(B_BURST_MAX);

    typedef enum logic [1:0] {StIdle, StRdA, StRdB} state_e;

    state_e     state_q;
    logic [7:0] streak_q;

    always_comb begin
        b_gnt = b_req & (~a_req | (streak_q < BurstMax));
        a_gnt = a_req & ~b_gnt;
        // Idle bus parks on port A so its address is already presented.
        if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we;
        end else begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_gnt & a_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            streak_q <= '0;
        end else begin
            if (a_gnt && !a_we) begin
                state_q <= StRdA;
            end else if (b_gnt && !b_we) begin
                state_q <= StRdB;
            end else begin
                state_q <= StIdle;
            end

            if (!a_req || a_gnt) begin
                streak_q <= '0;
            end else if (b_gnt && (streak_q < BurstMax)) begin
                streak_q <= streak_q + 8'd1;
            end
        end
    end

    assign a_rvalid = (state_q == StRdA);
    assign b_rvalid = (state_q == StRdB);
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a grant/streak/readback model.
module tb_mem_port_arbiter;

    localparam int unsigned BMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks   = 0;
    int failures = 0;

    // Model's grant decision for the cycle most recently checked.
    logic a_gnt_m = 1'b0;
    logic b_gnt_m = 1'b0;

    logic [15:0] ram [0:255];

    mem_port_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .B_BURST_MAX(BMAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 257) ^ 16'h5A3C;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous RAM, one-cycle read latency, read-before-write.
    initial begin : ram_model
        logic [15:0] rd;
        for (int i = 0; i < 256; i++) ram[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            rd = ram[mem_addr[7:0]];
            if (mem_we) ram[mem_addr[7:0]] = mem_wdata;
            mem_rdata <= rd;
        end
    end

    // Reference model: B wins unless A has waited through BMAX B grants.
    initial begin : model
        logic [15:0] shadow [0:255];
        int          streak_m;
        bit          pend_v, pend_b;
        logic [15:0] pend_d, addr, wd;
        bit          aw, bw, we;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        streak_m = 0;
        pend_v   = 0;
        pend_b   = 0;
        pend_d   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk1("rst_a_rvalid", a_rvalid, 1'b0);
                chk1("rst_b_rvalid", b_rvalid, 1'b0);
                streak_m = 0;
                pend_v   = 0;
                bw = b_req;
                aw = a_req && !bw;
                chk1("rst_a_gnt", a_gnt, aw);
                chk1("rst_b_gnt", b_gnt, bw);
                chk1("rst_mem_we", mem_we, bw ? b_we : (aw && a_we));
            end else begin
                chk1("a_rvalid", a_rvalid, pend_v && !pend_b);
                chk1("b_rvalid", b_rvalid, pend_v && pend_b);
                if (pend_v && pend_b)  chk16("b_rdata", b_rdata, pend_d);
                if (pend_v && !pend_b) chk16("a_rdata", a_rdata, pend_d);

                bw = b_req && (!a_req || streak_m < BMAX);
                aw = a_req && !bw;
                chk1("a_gnt", a_gnt, aw);
                chk1("b_gnt", b_gnt, bw);
                we   = bw ? b_we : (aw && a_we);
                addr = bw ? b_addr : a_addr;
                wd   = bw ? b_wdata : a_wdata;
                chk1("mem_we", mem_we, we);
                chk16("mem_addr", mem_addr, addr);
                if (we) chk16("mem_wdata", mem_wdata, wd);

                pend_v = 0;
                if (aw || bw) begin
                    if (we) begin
                        shadow[addr[7:0]] = wd;
                    end else begin
                        pend_v = 1;
                        pend_b = bw;
                        pend_d = shadow[addr[7:0]];
                    end
                end

                if (!a_req || aw) streak_m = 0;
                else if (bw && streak_m < BMAX) streak_m++;
            end
            a_gnt_m = aw;
            b_gnt_m = bw;
        end
    end

    initial begin : stim
        logic [9:0] pat;
        int pa, pb;
        reset   = 1'b1;
        a_req   = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req   = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #1;

        // Reset with both requesting.
        reset  = 1'b0;
        a_req  = 1'b1; b_req = 1'b1;
        a_addr = 16'h0040; b_addr = 16'h0041;
        @(negedge clk);
        chk1("reset_a_rvalid", a_rvalid, 1'b0);
        chk1("reset_b_rvalid", b_rvalid, 1'b0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk1("release_b_gnt", b_gnt, 1'b1);
        chk1("release_a_gnt", a_gnt, 1'b0);
        tick();
        a_req = 1'b0; b_req = 1'b0;

        // Single A read.
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        @(negedge clk);
        chk1("rd_a_gnt", a_gnt, 1'b1);
        chk1("rd_mem_we", mem_we, 1'b0);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        chk1("rd_a_rvalid", a_rvalid, 1'b1);
        chk16("rd_a_rdata", a_rdata, 16'hBEEF);
        chk1("rd_b_rvalid", b_rvalid, 1'b0);

        // A write then read back.
        tick();
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0020; a_wdata = 16'h1234;
        @(negedge clk);
        chk1("wr_mem_we", mem_we, 1'b1);
        chk1("wr_a_gnt", a_gnt, 1'b1);
        tick();
        a_we = 1'b0;
        @(negedge clk);
        chk1("wr_rd_mem_we", mem_we, 1'b0);
        chk1("wr_no_rvalid", a_rvalid, 1'b0);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        chk1("wr_rd_rvalid", a_rvalid, 1'b1);
        chk16("wr_rd_rdata", a_rdata, 16'h1234);

        // Contention: B,B,B,B,A,B,B,B,B,A (bit i = 1 means B wins cycle i).
        pat = 10'b0111101111;
        tick();
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = 16'h0030; b_addr = 16'h0031;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("cont_b_gnt", b_gnt, pat[i]);
            chk1("cont_a_gnt", a_gnt, !pat[i]);
            if (i > 0) begin
                chk1("cont_b_rvalid", b_rvalid, pat[i-1]);
                chk1("cont_a_rvalid", a_rvalid, !pat[i-1]);
            end
            if (i < 9) tick();
        end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk1("cont_last_a_rvalid", a_rvalid, 1'b1);

        // Streak clear: A requests 2 cycles, drops 3, then needs 4 more B grants.
        tick();
        a_req = 1'b1; b_req = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk1("sc_early_b_gnt", b_gnt, 1'b1);
            tick();
        end
        a_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk1("sc_idle_b_gnt", b_gnt, 1'b1);
            tick();
        end
        a_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("sc_b_gnt", b_gnt, k < 4);
            chk1("sc_a_gnt", a_gnt, k == 4);
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;

        // Reset with a B read in flight.
        tick();
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0055;
        @(negedge clk);
        chk1("rmr_b_gnt", b_gnt, 1'b1);
        #1;
        reset = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        chk1("rmr_b_rvalid_in_reset", b_rvalid, 1'b0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk1("rmr_b_rvalid_after", b_rvalid, 1'b0);
        chk1("rmr_a_rvalid_after", a_rvalid, 1'b0);

        // Randomized traffic; requests hold until the model says they were granted.
        for (int seg = 0; seg < 6; seg++) begin
            pa = $urandom_range(20, 100);
            pb = $urandom_range(20, 100);
            for (int c = 0; c < 500; c++) begin
                tick();
                if (!a_req || a_gnt_m) begin
                    a_req   = ($urandom_range(0, 99) < pa);
                    a_we    = $urandom_range(0, 1) == 1;
                    a_addr  = 16'($urandom_range(0, 255));
                    a_wdata = 16'($urandom);
                end
                if (!b_req || b_gnt_m) begin
                    b_req   = ($urandom_range(0, 99) < pb);
                    b_we    = $urandom_range(0, 1) == 1;
                    b_addr  = 16'($urandom_range(0, 255));
                    b_wdata = 16'($urandom);
                end
            end
        end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
